reg_dump: RTL and testbench
===========================

# reg_dump

Read-side companion to the 8×8-bit register file. On a start request it walks every register through one file read port, captures each value, and streams it out as address/data beats over a valid/ready handshake. It sits between the register file's read port (`OUT1ADDRESS`/`OUT1`) and a debug or trace sink. It gives the bench and debug logic a full register snapshot without touching the datapath write port.

## Interface
- `NREGS`, 8, number of registers scanned (addresses 0..NREGS-1)
- `ADDR_W`, 3, register address width
- `DATA_W`, 8, register data width

- `CLK`  in  1  clock; all state updates on the rising edge
- `RESET`  in  1  synchronous, active-high reset; sampled on `CLK` rising edge
- `START`  in  1  dump request; sampled only in IDLE
- `RDADDR`  out  ADDR_W  read address driven to the register file read port
- `RDDATA`  in  DATA_W  read data returned by the register file (combinational, settles within one cycle)
- `OUT_DATA`  out  DATA_W  beat payload
- `OUT_ADDR`  out  ADDR_W  register address of current beat
- `OUT_LAST`  out  1  marks final beat of a dump
- `OUT_VALID`  out  1  beat present
- `OUT_READY`  in  1  sink accepts beat
- `BUSY`  out  1  dump in progress
- `DONE`  out  1  one-cycle pulse after final beat accepted

## Operation
- States:
  - IDLE
  - SETUP: `RDADDR` driven; the cycle gives the file its read settle time.
  - PRESENT: beat held.
  - FINISH
- IDLE → SETUP on `START`=1:
  - `RDADDR`<=0, beat index <=0, `BUSY`<=1.
- SETUP → PRESENT (always, one cycle):
  - `OUT_DATA`<=`RDDATA`, `OUT_ADDR`<=`RDADDR`, `OUT_VALID`<=1.
  - `OUT_LAST`<=1 iff this is the final beat.
- PRESENT, handshake = `OUT_VALID` & `OUT_READY` at the edge:
  - No handshake: stay. `OUT_DATA`/`OUT_ADDR`/`OUT_LAST` held stable even if `RDDATA` changes.
  - Handshake, not final: `OUT_VALID`<=0, `RDADDR`<=`RDADDR`+1, go to SETUP.
  - Handshake, final: `OUT_VALID`<=0, `OUT_LAST`<=0, `BUSY`<=0, `DONE`<=1, go to FINISH.
- FINISH → IDLE (one cycle):
  - `DONE`<=0.
  - `START` is ignored in FINISH, so a continuously held `START` restarts after exactly one IDLE cycle.
- `START` while `BUSY`=1: ignored, no effect on the current dump.
- `OUT_READY` high outside PRESENT: no effect.
- `RDADDR` never exceeds NREGS-1. It holds its last value (NREGS-1) through FINISH/IDLE until the next start resets it to 0.

## Timing
- Reset value, all outputs: 0 (`RDADDR`, `OUT_DATA`, `OUT_ADDR`, `OUT_LAST`, `OUT_VALID`, `BUSY`, `DONE`); state IDLE.
- `RESET` has priority over all other inputs, including mid-dump. A dump aborted by reset produces no `DONE` and no further beats.
- `START` sampled at edge T:
  - `BUSY`=1 and `RDADDR`=0 from T+1.
  - First `OUT_VALID` from T+2.
- Each beat takes a minimum of 2 cycles (SETUP + PRESENT). With `OUT_READY` tied high, a full 8-register dump has `OUT_VALID` high on T+2, T+4, …, T+16.
- `DONE` is high in the cycle after the final handshake, and `BUSY` is 0 in that same cycle.
- `RDDATA` is sampled only at the SETUP→PRESENT edge. The read port must settle within one `CLK` period.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - An XOR accumulator is cleared on start and updated with `OUT_DATA` on each register beat handshake.
  - After register NREGS-1 is accepted, one extra beat is presented with no SETUP cycle: `OUT_DATA`=accumulated XOR, `OUT_ADDR`=0, `OUT_LAST`=1. It is entered directly from the handshake edge.
  - Register beat NREGS-1 has `OUT_LAST`=0.
  - `DONE` follows acceptance of the checksum beat.
- Not defined: no accumulator and no extra beat. `OUT_LAST`=1 on the register NREGS-1 beat.

## Test plan
- File preloaded reg[i]=0x10+i, `OUT_READY`=1, `START` pulsed at T → beats at T+2..T+16 carry (addr i, data 0x10+i); `OUT_LAST` only on addr 7; `DONE` at T+17; `BUSY` 0 from T+17.
- Same preload, `OUT_READY` low for 3 cycles on beat addr 3 while the file's reg3 is rewritten to 0xAA → `OUT_DATA` holds 0x13 until accepted; remaining beats are unchanged.
- `START` re-pulsed during beat addr 2 → ignored; exactly 8 beats, one `DONE`.
- `RESET` asserted while in PRESENT for addr 5 → next edge: all outputs 0, state IDLE; no `DONE`. A following `START` yields a full dump beginning at addr 0.
- `START` held high continuously → dumps repeat with `DONE` pulses separated by 18 cycles (one FINISH cycle, one IDLE cycle, 16 dump cycles).
- With `REG_DUMP_CHECKSUM_EN`, reg[i]=0x10+i → ninth beat `OUT_DATA`=0x00 (XOR of 0x10..0x17), `OUT_ADDR`=0, `OUT_LAST`=1. With reg0=0xFF and the rest 0 → checksum 0xFF.

Source files
------------

// File: rtl/reg_dump.sv
// Register-file snapshot streamer: walks every register through one read port and
// emits address/data beats on a valid/ready port. `REG_DUMP_CHECKSUM_EN adds an XOR checksum beat.
module reg_dump #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic [ADDR_W-1:0] RDADDR,
  input  logic [DATA_W-1:0] RDDATA,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic              OUT_LAST,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {IDLE, SETUP, PRESENT, CSUM, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hs;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   acc_q, acc_d;
`endif

  assign hs = out_valid_q & OUT_READY;

  always_comb begin
    state_d     = state_q;
    rdaddr_d    = rdaddr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = SETUP;
          rdaddr_d = '0;
          busy_d   = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d    = '0;
`endif
        end
      end
      SETUP: begin
        state_d     = PRESENT;
        out_data_d  = RDDATA;
        out_addr_d  = rdaddr_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (rdaddr_q == LAST_ADDR);
`endif
      end
      PRESENT: begin
        if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d = acc_q ^ out_data_q;
`endif
          if (rdaddr_q != LAST_ADDR) begin
            state_d     = SETUP;
            out_valid_d = 1'b0;
            rdaddr_d    = rdaddr_q + ADDR_W'(1);
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat follows straight from the handshake, no read needed.
            state_d    = CSUM;
            out_data_d = acc_q ^ out_data_q;
            out_addr_d = '0;
            out_last_d = 1'b1;
`else
            state_d     = FINISH;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
`endif
          end
        end
      end
      CSUM: begin
        if (hs) begin
          state_d     = FINISH;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rdaddr_q    <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdaddr_q    <= rdaddr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign RDADDR    = rdaddr_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_ADDR  = out_addr_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a small register-file model feeds RDDATA, expected
// beats come from hand-set tables. Build with REG_DUMP_CHECKSUM_EN to cover the checksum beat.
module tb_reg_dump;

  logic       CLK, RESET, START, OUT_READY;
  logic [2:0] RDADDR, OUT_ADDR;
  logic [7:0] RDDATA, OUT_DATA;
  logic       OUT_LAST, OUT_VALID, BUSY, DONE;

  logic [7:0] regs [8];
  logic [7:0] exp_d [8];
  int checks = 0;
  int failures = 0;

  assign RDDATA = regs[RDADDR];

  reg_dump #(.NREGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RDADDR(RDADDR), .RDDATA(RDDATA),
    .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR), .OUT_LAST(OUT_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one cycle after the START edge; walks all beats and the DONE pulse.
  task automatic dump_check(input string tag, input int stall_at, input int restart_at,
                            input logic [7:0] csum);
    chk({tag, ".busy_t1"}, BUSY, 1);
    chk({tag, ".rdaddr_t1"}, RDADDR, 0);
    chk({tag, ".valid_t1"}, OUT_VALID, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("%s.valid%0d", tag, i), OUT_VALID, 1);
      chk($sformatf("%s.addr%0d", tag, i), OUT_ADDR, i);
      chk($sformatf("%s.data%0d", tag, i), OUT_DATA, exp_d[i]);
`ifdef REG_DUMP_CHECKSUM_EN
      chk($sformatf("%s.last%0d", tag, i), OUT_LAST, 0);
`else
      chk($sformatf("%s.last%0d", tag, i), OUT_LAST, (i == 7));
`endif
      if (i == stall_at) begin
        OUT_READY = 1'b0;
        regs[i] = 8'hAA;
        for (int s = 0; s < 3; s++) begin
          step();
          chk($sformatf("%s.stall_valid%0d", tag, s), OUT_VALID, 1);
          chk($sformatf("%s.stall_data%0d", tag, s), OUT_DATA, exp_d[i]);
          chk($sformatf("%s.stall_addr%0d", tag, s), OUT_ADDR, i);
        end
        OUT_READY = 1'b1;
      end
      if (i == restart_at) START = 1'b1;
      step();
      START = 1'b0;
      if (i < 7) begin
        chk($sformatf("%s.gap_valid%0d", tag, i), OUT_VALID, 0);
        chk($sformatf("%s.gap_busy%0d", tag, i), BUSY, 1);
        chk($sformatf("%s.gap_done%0d", tag, i), DONE, 0);
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    chk({tag, ".csum_valid"}, OUT_VALID, 1);
    chk({tag, ".csum_data"}, OUT_DATA, csum);
    chk({tag, ".csum_addr"}, OUT_ADDR, 0);
    chk({tag, ".csum_last"}, OUT_LAST, 1);
    chk({tag, ".csum_busy"}, BUSY, 1);
    step();
`else
    chk({tag, ".csum_unused"}, {24'd0, csum} & 32'h0, 0);
`endif
    chk({tag, ".done"}, DONE, 1);
    chk({tag, ".done_busy"}, BUSY, 0);
    chk({tag, ".done_valid"}, OUT_VALID, 0);
    chk({tag, ".done_last"}, OUT_LAST, 0);
    step();
    chk({tag, ".done_pulse"}, DONE, 0);
    chk({tag, ".rdaddr_hold"}, RDADDR, 7);
    step();
    chk({tag, ".idle_busy"}, BUSY, 0);
    chk({tag, ".idle_done"}, DONE, 0);
  endtask

  task automatic preload_inc();
    for (int i = 0; i < 8; i++) begin
      regs[i] = 8'h10 + 8'(i);
      exp_d[i] = 8'h10 + 8'(i);
    end
  endtask

  initial begin
    int d1, d2, c;
    RESET = 1'b1; START = 1'b0; OUT_READY = 1'b0;
    preload_inc();
    step(); step();
    RESET = 1'b0;
    chk("rst.rdaddr", RDADDR, 0);
    chk("rst.data", OUT_DATA, 0);
    chk("rst.addr", OUT_ADDR, 0);
    chk("rst.last", OUT_LAST, 0);
    chk("rst.valid", OUT_VALID, 0);
    chk("rst.busy", BUSY, 0);
    chk("rst.done", DONE, 0);

    // Full dump, ready tied high.
    OUT_READY = 1'b1;
    START = 1'b1; step(); START = 1'b0;
    dump_check("basic", -1, -1, 8'h00);

    // Backpressure on beat 3 while reg3 is rewritten.
    preload_inc();
    START = 1'b1; step(); START = 1'b0;
    dump_check("stall", 3, -1, 8'h00);

    // START re-pulsed mid-dump is ignored.
    preload_inc();
    START = 1'b1; step(); START = 1'b0;
    dump_check("restart", -1, 2, 8'h00);

    // Reset while beat 5 is presented.
    START = 1'b1; step(); START = 1'b0;
    repeat (11) step();
    chk("abort.addr5", OUT_ADDR, 5);
    chk("abort.valid5", OUT_VALID, 1);
    RESET = 1'b1; step(); RESET = 1'b0;
    chk("abort.rdaddr", RDADDR, 0);
    chk("abort.data", OUT_DATA, 0);
    chk("abort.addr", OUT_ADDR, 0);
    chk("abort.valid", OUT_VALID, 0);
    chk("abort.busy", BUSY, 0);
    chk("abort.done", DONE, 0);
    step();
    chk("abort.no_done", DONE, 0);
    chk("abort.stays_idle", BUSY, 0);
    START = 1'b1; step(); START = 1'b0;
    dump_check("after_abort", -1, -1, 8'h00);

    // Sparse data: only reg0 non-zero.
    for (int i = 0; i < 8; i++) begin
      regs[i] = 8'h00;
      exp_d[i] = 8'h00;
    end
    regs[0] = 8'hFF; exp_d[0] = 8'hFF;
    START = 1'b1; step(); START = 1'b0;
    dump_check("sparse", -1, -1, 8'hFF);

    // START held high: DONE pulses 18 cycles apart.
    preload_inc();
    d1 = -1; d2 = -1;
    START = 1'b1; step();
    for (c = 0; c < 60; c++) begin
      if (DONE === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      step();
    end
    START = 1'b0;
    chk("held.first_done", d1, 16);
    chk("held.period", d2 - d1, 18);
    repeat (40) step();
    chk("held.settle_busy", BUSY, 0);
    chk("held.settle_valid", OUT_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
